// File: rtl/alu_pkg.sv
// Shared ALU opcodes, flag bit positions and arbiter state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // flags word is {branch_force_add, store_force_add, addi_sub}
  localparam int FLAG_ADDI_SUB         = 0;
  localparam int FLAG_STORE_FORCE_ADD  = 1;
  localparam int FLAG_BRANCH_FORCE_ADD = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_e;

  function automatic logic op_is_legal(input logic [3:0] op, input logic [2:0] flags);
    return flags[FLAG_BRANCH_FORCE_ADD] | flags[FLAG_STORE_FORCE_ADD] |
           (op <= ALU_SUB) | (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU datapath: either force flag turns any op into an add.
// Zero latency, no flow control; unknown opcodes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [2:0]      flags_i,
  output logic [XLEN-1:0] res_o
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           force_add;

  assign shamt     = b_i[SHW-1:0];
  assign force_add = flags_i[FLAG_BRANCH_FORCE_ADD] | flags_i[FLAG_STORE_FORCE_ADD];

  always_comb begin
    res_o = '0;
    if (force_add) begin
      res_o = a_i + b_i;
    end else begin
      case (op_i)
        // addi_sub on ADD marks a decoded subtract that arrived on the add opcode
        ALU_ADD:  res_o = flags_i[FLAG_ADDI_SUB] ? (a_i - b_i) : (a_i + b_i);
        ALU_SLL:  res_o = a_i << shamt;
        ALU_SLT:  res_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
        ALU_SLTU: res_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
        ALU_XOR:  res_o = a_i ^ b_i;
        ALU_SRL:  res_o = a_i >> shamt;
        ALU_OR:   res_o = a_i | b_i;
        ALU_AND:  res_o = a_i & b_i;
        ALU_SUB:  res_o = a_i - b_i;
        ALU_SRA:  res_o = $unsigned($signed(a_i) >>> shamt);
        default:  res_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two ports; request to response in 2 cycles, 1 op per 3 cycles.
// Response holds until the owner's rsp_ready; optional counters under ALU_ARB_PERF_CNT_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_w_i,
  input  logic            rst_w_i_h,
  input  logic [1:0]      req_valid_w_i,
  output logic [1:0]      req_ready_w_o,
  input  logic [3:0]      req0_op_w_i,
  input  logic [3:0]      req1_op_w_i,
  input  logic [XLEN-1:0] req0_a_w_i,
  input  logic [XLEN-1:0] req1_a_w_i,
  input  logic [XLEN-1:0] req0_b_w_i,
  input  logic [XLEN-1:0] req1_b_w_i,
  input  logic [2:0]      req0_flags_w_i,
  input  logic [2:0]      req1_flags_w_i,
  output logic [1:0]      rsp_valid_w_o,
  input  logic [1:0]      rsp_ready_w_i,
  output logic [XLEN-1:0] rsp_data_w_o,
  output logic            rsp_err_w_o_h
`ifdef ALU_ARB_PERF_CNT_EN
  ,
  output logic [31:0]     grant_cnt0_w_o,
  output logic [31:0]     grant_cnt1_w_o,
  output logic [31:0]     stall_cnt_w_o
`endif
);

  arb_state_e      state_q, state_d;
  logic            rr_q, rr_d;
  logic            owner_q, owner_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]      flags_q, flags_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [XLEN-1:0] alu_res;

  logic both_vld, any_vld, grant_id, hs;

  assign both_vld = &req_valid_w_i;
  assign any_vld  = |req_valid_w_i;
  assign grant_id = both_vld ? rr_q : req_valid_w_i[1];
  assign hs       = (state_q == ST_IDLE) & any_vld & ~rst_w_i_h;

  alu #(.XLEN(XLEN)) u_alu (
    .op_i    (op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .flags_i (flags_q),
    .res_o   (alu_res)
  );

  always_ff @(posedge clk_w_i) begin
    if (rst_w_i_h) begin
      state_q    <= ST_IDLE;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      flags_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      flags_q    <= flags_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_HOLD;
      ST_HOLD: if (rsp_ready_w_i[owner_q]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rr_d       = rr_q;
    owner_d    = owner_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    flags_d    = flags_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (hs) begin
      rr_d    = ~grant_id;
      owner_d = grant_id;
      op_d    = grant_id ? req1_op_w_i    : req0_op_w_i;
      a_d     = grant_id ? req1_a_w_i     : req0_a_w_i;
      b_d     = grant_id ? req1_b_w_i     : req0_b_w_i;
      flags_d = grant_id ? req1_flags_w_i : req0_flags_w_i;
    end
    if (state_q == ST_EXEC) begin
      rsp_err_d  = ~op_is_legal(op_q, flags_q);
      rsp_data_d = rsp_err_d ? '0 : alu_res;
    end
  end

  always_comb begin
    req_ready_w_o = 2'b00;
    rsp_valid_w_o = 2'b00;
    if (hs) req_ready_w_o = {grant_id, ~grant_id};
    if (state_q == ST_HOLD) rsp_valid_w_o = {owner_q, ~owner_q};
  end

  assign rsp_data_w_o  = rsp_data_q;
  assign rsp_err_w_o_h = rsp_err_q;

`ifdef ALU_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt0_q, grant_cnt0_d;
  logic [31:0] grant_cnt1_q, grant_cnt1_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    grant_cnt0_d = grant_cnt0_q + {31'd0, hs & ~grant_id};
    grant_cnt1_d = grant_cnt1_q + {31'd0, hs & grant_id};
    // a contended IDLE cycle always grants one port, so the other one stalls
    stall_cnt_d  = stall_cnt_q + {31'd0, hs & both_vld};
  end

  always_ff @(posedge clk_w_i) begin
    if (rst_w_i_h) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign grant_cnt0_w_o = grant_cnt0_q;
  assign grant_cnt1_w_o = grant_cnt1_q;
  assign stall_cnt_w_o  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: constant vector table, reference-model scoreboard, and hand-written
// sequences for contention, backpressure and reset-in-HOLD.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req1_a, req0_b, req1_b;
  logic [2:0]  req0_flags, req1_flags;
  logic [31:0] rsp_data;
  logic        rsp_err;
`ifdef ALU_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(32)) dut (
    .clk_w_i        (clk),
    .rst_w_i_h      (rst),
    .req_valid_w_i  (req_valid),
    .req_ready_w_o  (req_ready),
    .req0_op_w_i    (req0_op),
    .req1_op_w_i    (req1_op),
    .req0_a_w_i     (req0_a),
    .req1_a_w_i     (req1_a),
    .req0_b_w_i     (req0_b),
    .req1_b_w_i     (req1_b),
    .req0_flags_w_i (req0_flags),
    .req1_flags_w_i (req1_flags),
    .rsp_valid_w_o  (rsp_valid),
    .rsp_ready_w_i  (rsp_ready),
    .rsp_data_w_o   (rsp_data),
    .rsp_err_w_o_h  (rsp_err)
`ifdef ALU_ARB_PERF_CNT_EN
    ,
    .grant_cnt0_w_o (grant_cnt0),
    .grant_cnt1_w_o (grant_cnt1),
    .stall_cnt_w_o  (stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model, returns {err, data}
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [2:0] f);
    logic [31:0] r;
    logic        e;
    logic [4:0]  sh;
    r  = 32'd0;
    e  = 1'b0;
    sh = b[4:0];
    if (f[2] || f[1]) r = a + b;
    else case (op)
      4'd0:  r = f[0] ? a - b : a + b;
      4'd1:  r = a << sh;
      4'd2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  r = (a < b) ? 32'd1 : 32'd0;
      4'd4:  r = a ^ b;
      4'd5:  r = a >> sh;
      4'd6:  r = a | b;
      4'd7:  r = a & b;
      4'd8:  r = a - b;
      4'd13: r = $unsigned($signed(a) >>> sh);
      default: e = 1'b1;
    endcase
    return {e, r};
  endfunction

  typedef struct {
    logic        p;
    logic [32:0] r;
  } sb_ent_t;
  sb_ent_t sb[$];

  always @(negedge clk) begin
    sb_ent_t ent;
    if (rst) begin
      sb.delete();
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rsp_valid[p] && rsp_ready[p]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got response on port %0d data %h, expected none", p, rsp_data);
          end else begin
            ent = sb.pop_front();
            chk("sb_port", 64'(p), 64'(ent.p));
            chk("sb_data", 64'(rsp_data), 64'(ent.r[31:0]));
            chk("sb_err", 64'(rsp_err), 64'(ent.r[32]));
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (req_valid[p] && req_ready[p]) begin
          ent.p = p[0];
          ent.r = (p == 0) ? model(req0_op, req0_a, req0_b, req0_flags)
                           : model(req1_op, req1_a, req1_b, req1_flags);
          sb.push_back(ent);
        end
      end
    end
  end

  typedef struct {
    logic        p;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;
  vec_t vt[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic p, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] f);
    if (p) begin
      req1_op = op; req1_a = a; req1_b = b; req1_flags = f;
    end else begin
      req0_op = op; req0_a = a; req0_b = b; req0_flags = f;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    oh = v.p ? 2'b10 : 2'b01;
    set_req(v.p, v.op, v.a, v.b, v.f);
    req_valid = oh;
    @(negedge clk);
    chk("vec_ready_same_cycle", 64'(req_ready), 64'(oh));
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("vec_no_early_rsp", 64'(rsp_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("vec_rsp_valid", 64'(rsp_valid), 64'(oh));
    chk("vec_rsp_data", 64'(rsp_data), 64'(v.exp_d));
    chk("vec_rsp_err", 64'(rsp_err), 64'(v.exp_e));
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid != 2'b00) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(n < 20), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int g, stall_obs, n;

    vt[0]  = '{1'b0, ALU_ADD,  32'h5,        32'h3,        3'b000, 32'h8,        1'b0};
    vt[1]  = '{1'b0, ALU_SUB,  32'd10,       32'd3,        3'b001, 32'h7,        1'b0};
    vt[2]  = '{1'b1, ALU_SRA,  32'h8000_0000, 32'd4,       3'b000, 32'hF800_0000, 1'b0};
    vt[3]  = '{1'b0, 4'b1111,  32'h100,      32'h20,       3'b000, 32'h0,        1'b1};
    vt[4]  = '{1'b1, 4'b1111,  32'h100,      32'h20,       3'b010, 32'h120,      1'b0};
    vt[5]  = '{1'b1, 4'b1110,  32'h1,        32'h2,        3'b100, 32'h3,        1'b0};
    vt[6]  = '{1'b0, ALU_XOR,  32'hFF00_FF00, 32'h0F0F_0F0F, 3'b000, 32'hF00F_F00F, 1'b0};
    vt[7]  = '{1'b0, ALU_SLT,  32'hFFFF_FFFF, 32'h1,       3'b000, 32'h1,        1'b0};
    vt[8]  = '{1'b1, ALU_SLTU, 32'hFFFF_FFFF, 32'h1,       3'b000, 32'h0,        1'b0};
    vt[9]  = '{1'b0, ALU_SLL,  32'h1,        32'd31,       3'b000, 32'h8000_0000, 1'b0};
    vt[10] = '{1'b1, ALU_SRL,  32'h8000_0000, 32'd4,       3'b000, 32'h0800_0000, 1'b0};
    vt[11] = '{1'b0, 4'b1001,  32'h7,        32'h7,        3'b000, 32'h0,        1'b1};
    vt[12] = '{1'b1, 4'b1100,  32'h7,        32'h7,        3'b000, 32'h0,        1'b1};
    vt[13] = '{1'b0, 4'b1110,  32'h7,        32'h7,        3'b001, 32'h0,        1'b1};
    vt[14] = '{1'b1, ALU_OR,   32'hF0F0_0000, 32'h0000_0F0F, 3'b000, 32'hF0F0_0F0F, 1'b0};
    vt[15] = '{1'b0, ALU_AND,  32'hFFFF_0000, 32'h1234_5678, 3'b000, 32'h1234_0000, 1'b0};

    rst = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    set_req(1'b0, ALU_ADD, 32'h0, 32'h0, 3'b000);
    set_req(1'b1, ALU_ADD, 32'h0, 32'h0, 3'b000);
    tick();
    tick();
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
`ifdef ALU_ARB_PERF_CNT_EN
    chk("reset_grant_cnt0", 64'(grant_cnt0), 64'd0);
    chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    tick();
    req_valid = 2'b00;
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) run_vec(vt[i]);
    drain();

    // Contention: both valid continuously, grants must alternate starting at port 0
    do_reset();
    set_req(1'b0, ALU_SUB, 32'd10, 32'd3, 3'b001);
    set_req(1'b1, ALU_SRA, 32'h8000_0000, 32'd4, 3'b000);
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    g = 0;
    stall_obs = 0;
    n = 0;
    while (g < 4 && n < 40) begin
      @(negedge clk);
      if (rsp_valid[0]) chk("contend_data0", 64'(rsp_data), 64'h7);
      if (rsp_valid[1]) chk("contend_data1", 64'(rsp_data), 64'hF800_0000);
      if (req_ready != 2'b00) begin
        if (req_valid == 2'b11) stall_obs++;
        chk("contend_grant_order", 64'(req_ready), (g % 2 == 0) ? 64'd1 : 64'd2);
        g++;
      end
      tick();
      n++;
    end
    req_valid = 2'b00;
    chk("contend_grant_count", 64'(g), 64'd4);
    @(negedge clk);
`ifdef ALU_ARB_PERF_CNT_EN
    chk("perf_grant_cnt0", 64'(grant_cnt0), 64'd2);
    chk("perf_grant_cnt1", 64'(grant_cnt1), 64'd2);
    chk("perf_stall_cnt", 64'(stall_cnt), 64'(stall_obs));
`endif
    tick();
    drain();

    // Backpressure on port 1 while port 0 waits
    rsp_ready = 2'b01;
    set_req(1'b1, ALU_ADD, 32'h11, 32'h22, 3'b000);
    req_valid = 2'b10;
    @(negedge clk);
    chk("bp_grant1", 64'(req_ready), 64'd2);
    tick();
    req_valid = 2'b00;
    tick();
    set_req(1'b0, ALU_ADD, 32'h5, 32'h3, 3'b000);
    req_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid_held", 64'(rsp_valid), 64'd2);
      chk("bp_rsp_data_held", 64'(rsp_data), 64'h33);
      chk("bp_req_ready_low", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_release_cycle_ready", 64'(req_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("bp_grant0_after_release", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    drain();

    // Reset while HOLD: response dropped, rr pointer back to port 0
    rsp_ready = 2'b00;
    set_req(1'b0, ALU_ADD, 32'h1, 32'h2, 3'b000);
    req_valid = 2'b01;
    @(negedge clk);
    chk("rst_hold_grant0", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    tick();
    @(negedge clk);
    chk("rst_hold_in_hold", 64'(rsp_valid), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hold_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_hold_rsp_data", 64'(rsp_data), 64'd0);
    rsp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("rst_hold_no_stale_rsp", 64'(rsp_valid), 64'd0);
    end
    tick();
    set_req(1'b1, ALU_ADD, 32'h4, 32'h4, 3'b000);
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_rr_back_to_0", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `alu` instance between two requesters: port 0 is the integer execute path, port 1 is the address-generation path.
- Round-robin arbitration; operands are latched, the ALU evaluates for one cycle, and the registered result is returned with valid/ready backpressure.
- Sits between the decode/issue logic and the combinational ALU datapath. The arbiter is the sole driver of all ALU inputs.

Parameters:
- XLEN, 32, operand/result width; must equal the ALU datapath width.

Ports:
- clk_w_i  in  1  clock; all state updates on rising edge.
- rst_w_i_h  in  1  synchronous reset, active-high.
- req_valid_w_i  in  2  per-port request valid.
- req_ready_w_o  out  2  per-port request accept; one-hot or zero.
- req0_op_w_i / req1_op_w_i  in  4  ALU control code per port.
- req0_a_w_i / req1_a_w_i  in  XLEN  operand A per port.
- req0_b_w_i / req1_b_w_i  in  XLEN  operand B per port.
- req0_flags_w_i / req1_flags_w_i  in  3  {branch_force_add, store_force_add, addi_sub} per port.
- rsp_valid_w_o  out  2  per-port response valid; one-hot or zero.
- rsp_ready_w_i  in  2  per-port response accept.
- rsp_data_w_o  out  XLEN  registered ALU result, shared by both ports.
- rsp_err_w_o_h  out  1  illegal opcode flag accompanying the response.

Behaviour:
- States: IDLE, EXEC, HOLD. Reset: state=IDLE, rr pointer=port 0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
- IDLE: req_ready is combinational, asserted only for the granted port.
  - Grant rule: if both ports are valid, grant the port named by the rr pointer; otherwise grant the single valid port.
  - On a handshake (valid&ready), latch op, a, b, flags and the owner id, flip the rr pointer to the other port, and go to EXEC.
  - No valid request: stay in IDLE.
- EXEC: ALU inputs are driven from the latched registers.
  - At the clock edge, capture alu_res into rsp_data and compute rsp_err, then go to HOLD.
  - req_ready=0 in this state.
- HOLD: rsp_valid[owner]=1; rsp_data and rsp_err are held stable.
  - When rsp_ready[owner]=1, clear rsp_valid and go to IDLE. rsp_ready on the non-owner port is ignored.
- Latency and throughput: handshake in cycle N gives rsp_valid in cycle N+2. Fastest re-accept is cycle N+3, so peak throughput is 1 op per 3 cycles.
- Legal ops: 0000–1000 and 1101.
  - Any other op with both force flags clear: rsp_data=0, rsp_err=1, and the ALU output is ignored.
  - Any op with a force flag set is legal, because the ALU adds in that case.
- Requesters must hold op/a/b/flags stable while valid and not ready; the arbiter does not sample them outside the handshake.
- Between operations, ALU inputs hold their last latched values; they are never driven X.
- Reset asserted in any state: outputs take their reset values next cycle, and any in-flight response is discarded (never delivered).
- Both rsp_ready bits high while HOLD: only the owner's bit counts.

Optional Feature:
- Macro: ALU_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs grant_cnt0_w_o and grant_cnt1_w_o (32 bits each), plus stall_cnt_w_o (32 bits).
  - grant_cnt counts handshakes per port.
  - stall_cnt counts cycles in IDLE where a valid request was not granted because the other port won arbitration.
  - All counters clear on reset and wrap at 2^32.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode localparams (ALU_ADD=4'b0000 … ALU_SUB=4'b1000, ALU_SRA=4'b1101).
  - Flag bit indices.
  - Arbiter state encoding (IDLE/EXEC/HOLD).
- Sub-module: instantiate the existing `alu` as the single datapath child. The round-robin grant logic stays inline; it is too small for its own module.

Test Plan:
- Port 0 only: op=0000, a=0x0000_0005, b=0x0000_0003 -> req_ready[0] in the same cycle; rsp_valid[0] 2 cycles later with rsp_data=0x0000_0008, rsp_err=0.
- Both ports valid continuously, rsp_ready tied to 1:
  - Port 0: SUB, addi_sub=1, a=10, b=3. Port 1: SRA, a=0x8000_0000, b=4.
  - Required: grants alternate 0,1,0,1; results 0x0000_0007 and 0xF800_0000.
- Backpressure: rsp_ready[1]=0 for 5 cycles while port 0 requests:
  - rsp_valid[1] and rsp_data stay stable throughout, and req_ready stays 0.
  - Port 0 is granted in the cycle after rsp_ready[1] rises.
- Illegal op 1111, flags=000 -> rsp_err=1, rsp_data=0. Same op with store_force_add=1, a=0x100, b=0x20 -> rsp_err=0, rsp_data=0x120.
- Reset asserted in HOLD -> next cycle rsp_valid=0 and state=IDLE; the dropped response never appears; rr pointer returns to port 0.
- With ALU_ARB_PERF_CNT_EN: after 4 contended grants, grant_cnt0=2 and grant_cnt1=2, and stall_cnt equals the observed cycles where a valid request lost arbitration.
